frame_sequencer: RTL and testbench

//  Per-frame controller for the vertex-shader -> rasterizer datapath, in the clk_pix domain.
//  - At each vsync leading edge: advances the rotation angle, starts one vertex-shader job and

---
 rtl/raster_pkg.sv | 13 +
 rtl/angle_wrap.sv | 21 ++
 rtl/frame_sequencer.sv | 115 +++++++++++
 tb/tb_frame_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared widths, angle modulus and FSM encoding for the frame sequencer
package raster_pkg;

  localparam int ANGLE_W   = 9;
  localparam int ANGLE_MOD = 360;
  localparam int COORD_W   = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } seq_state_t;

endpackage

// File: rtl/angle_wrap.sv
// rtl/angle_wrap.sv - combinational (angle + step) mod ANGLE_MOD
module angle_wrap #(
  parameter int ANGLE_W   = raster_pkg::ANGLE_W,
  parameter int ANGLE_MOD = raster_pkg::ANGLE_MOD
) (
  input  logic [ANGLE_W-1:0] angle,
  input  logic [2:0]         step,
  output logic [ANGLE_W-1:0] angle_next
);

  localparam logic [ANGLE_W:0] MOD_EXT = (ANGLE_W + 1)'(ANGLE_MOD);

  logic [ANGLE_W:0] sum;

  // One extra bit keeps the carry so a single conditional subtract wraps correctly.
  always_comb begin
    sum        = {1'b0, angle} + {{(ANGLE_W - 2){1'b0}}, step};
    angle_next = (sum >= MOD_EXT) ? ANGLE_W'(sum - MOD_EXT) : sum[ANGLE_W-1:0];
  end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame vertex-shader job launcher with double-buffered rasterizer vertices
module frame_sequencer #(
  parameter int ANGLE_W   = raster_pkg::ANGLE_W,
  parameter int ANGLE_MOD = raster_pkg::ANGLE_MOD,
  parameter int COORD_W   = raster_pkg::COORD_W,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic               clk_pix,
  input  logic               resetn,
  input  logic               vsync,
  input  logic               run,
  input  logic [2:0]         angle_step,
  input  logic               clr_overrun,
  output logic [ANGLE_W-1:0] vs_angle,
  output logic               vs_start,
  input  logic               vs_done,
  input  logic [COORD_W-1:0] vs_ax,
  input  logic [COORD_W-1:0] vs_ay,
  input  logic [COORD_W-1:0] vs_bx,
  input  logic [COORD_W-1:0] vs_by,
  input  logic [COORD_W-1:0] vs_cx,
  input  logic [COORD_W-1:0] vs_cy,
  output logic [COORD_W-1:0] ax,
  output logic [COORD_W-1:0] ay,
  output logic [COORD_W-1:0] bx,
  output logic [COORD_W-1:0] by,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               overrun
);

  typedef logic [5:0][COORD_W-1:0] tri_t;

  raster_pkg::seq_state_t state;
  logic                   vsync_d;
  logic                   vsync_edge;
  logic                   shadow_valid;
  tri_t                   shadow;
  tri_t                   front;
  tri_t                   vs_tri;
  logic [ANGLE_W-1:0]     angle_next;

  assign vsync_edge = (vsync == VSYNC_POL) && (vsync_d != VSYNC_POL);
  assign vs_tri     = {vs_ax, vs_ay, vs_bx, vs_by, vs_cx, vs_cy};
  assign {ax, ay, bx, by, cx, cy} = front;

  angle_wrap #(
    .ANGLE_W  (ANGLE_W),
    .ANGLE_MOD(ANGLE_MOD)
  ) u_angle_wrap (
    .angle     (vs_angle),
    .step      (angle_step),
    .angle_next(angle_next)
  );

  always_ff @(posedge clk_pix) begin
    if (!resetn) begin
      // vsync_d resets to the active level so no edge can be seen before vsync goes inactive.
      vsync_d      <= VSYNC_POL;
      state        <= raster_pkg::IDLE;
      vs_angle     <= '0;
      vs_start     <= 1'b0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      front        <= '0;
      frame_cnt    <= '0;
      overrun      <= 1'b0;
    end else begin
      vsync_d  <= vsync;
      vs_start <= 1'b0;
      if (clr_overrun) overrun <= 1'b0;

      case (state)
        raster_pkg::IDLE: begin
          if (vsync_edge) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (shadow_valid) begin
              front        <= shadow;
              shadow_valid <= 1'b0;
            end
            if (run) begin
              vs_angle <= angle_next;
              vs_start <= 1'b1;
              state    <= raster_pkg::BUSY;
            end
          end
        end
        raster_pkg::BUSY: begin
          // A completion landing on the edge is on time and bypasses the shadow.
          if (vs_done && vsync_edge) begin
            front     <= vs_tri;
            frame_cnt <= frame_cnt + 1'b1;
            if (run) begin
              vs_angle <= angle_next;
              vs_start <= 1'b1;
            end else begin
              state <= raster_pkg::IDLE;
            end
          end else if (vs_done) begin
            shadow       <= vs_tri;
            shadow_valid <= 1'b1;
            state        <= raster_pkg::IDLE;
          end else if (vsync_edge) begin
            overrun   <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= raster_pkg::IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scenario and randomized checks of frame_sequencer against a frame-level model
module tb_frame_sequencer;

  localparam int AW = 9;
  localparam int CW = 10;
  localparam int NW = 16;

  logic          clk_pix = 1'b0;
  logic          resetn = 1'b0;
  logic          vsync = 1'b1;
  logic          run = 1'b0;
  logic [2:0]    angle_step = 3'd0;
  logic          clr_overrun = 1'b0;
  logic          vs_done = 1'b0;
  logic [CW-1:0] drv [6];
  logic [AW-1:0] vs_angle;
  logic          vs_start;
  logic [CW-1:0] ax, ay, bx, by, cx, cy;
  logic [NW-1:0] frame_cnt;
  logic          overrun;
  logic [CW-1:0] obs [6];

  int checks = 0;
  int errors = 0;

  bit m_busy, m_has_shadow, m_ov, m_start, m_prev_vs;
  int m_angle, m_frames;
  int m_front [6];
  int m_shadow [6];
  int n_starts = 0;
  int last_drv [6];
  int last_done [6];

  frame_sequencer dut (
    .clk_pix(clk_pix), .resetn(resetn), .vsync(vsync), .run(run),
    .angle_step(angle_step), .clr_overrun(clr_overrun),
    .vs_angle(vs_angle), .vs_start(vs_start), .vs_done(vs_done),
    .vs_ax(drv[0]), .vs_ay(drv[1]), .vs_bx(drv[2]), .vs_by(drv[3]), .vs_cx(drv[4]), .vs_cy(drv[5]),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .frame_cnt(frame_cnt), .overrun(overrun)
  );

  always #5 clk_pix = ~clk_pix;

  always_comb begin
    obs[0] = ax; obs[1] = ay; obs[2] = bx;
    obs[3] = by; obs[4] = cx; obs[5] = cy;
  end

  // Frame-level reference: a job is either outstanding or not, and each vsync falling edge
  // is a frame boundary at which the pending result is shown and the next job launched.
  task automatic model_step();
    bit edge_m;
    if (!resetn) begin
      m_busy = 0; m_has_shadow = 0; m_ov = 0; m_start = 0; m_prev_vs = 0;
      m_angle = 0; m_frames = 0;
      for (int k = 0; k < 6; k++) begin m_front[k] = 0; m_shadow[k] = 0; end
      return;
    end
    edge_m    = (vsync == 1'b0) && (m_prev_vs == 1'b1);
    m_prev_vs = vsync;
    m_start   = 0;
    if (clr_overrun) m_ov = 0;
    if (edge_m) m_frames = (m_frames + 1) % 65536;
    if (!m_busy) begin
      if (edge_m) begin
        if (m_has_shadow) begin m_front = m_shadow; m_has_shadow = 0; end
        if (run) begin m_angle = (m_angle + angle_step) % 360; m_start = 1; m_busy = 1; end
      end
    end else if (vs_done && edge_m) begin
      m_front = last_drv;
      if (run) begin m_angle = (m_angle + angle_step) % 360; m_start = 1; end
      else m_busy = 0;
    end else if (vs_done) begin
      m_shadow = last_drv; m_has_shadow = 1; m_busy = 0;
    end else if (edge_m) begin
      m_ov = 1;
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 6; k++) begin
      drv[k] = CW'($urandom);
      last_drv[k] = int'(drv[k]);
    end
    model_step();
    if (vs_done) last_done = last_drv;
    @(posedge clk_pix);
    #1;
    if (vs_start) n_starts++;
  endtask

  task automatic frame(input int len, input int done_at);
    for (int i = 0; i < len; i++) begin
      vsync = (i < 2) ? 1'b0 : 1'b1;
      vs_done = (i == done_at);
      tick();
    end
    vs_done = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; run = 1'b1; angle_step = 3'd3; vsync = 1'b1; vs_done = 1'b1;
    repeat (3) tick();
    checks++; if (vs_angle !== '0) begin errors++; $display("FAIL reset_angle: got %0d expected 0", vs_angle); end
    checks++; if (vs_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b expected 0", vs_start); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (obs[k] !== '0) begin errors++; $display("FAIL reset_front[%0d]: got %0d expected 0", k, obs[k]); end
    end
    resetn = 1'b1; vs_done = 1'b0; run = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cap [6];
    int s0;
    for (int k = 0; k < 6; k++) cap[k] = 0;
    run = 1'b1; angle_step = 3'd1; s0 = n_starts;
    for (int f = 1; f <= 3; f++) begin
      frame(40, 21);
      checks++; if (vs_angle !== AW'(f)) begin errors++; $display("FAIL basic_angle: got %0d expected %0d", vs_angle, f); end
      checks++; if (frame_cnt !== NW'(f)) begin errors++; $display("FAIL basic_frame_cnt: got %0d expected %0d", frame_cnt, f); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %0b expected 0", overrun); end
      for (int k = 0; k < 6; k++) begin
        checks++; if (obs[k] !== CW'(cap[k])) begin errors++; $display("FAIL basic_front[%0d]: got %0d expected %0d", k, obs[k], cap[k]); end
      end
      cap = last_done;
    end
    checks++; if (n_starts - s0 !== 3) begin errors++; $display("FAIL basic_starts: got %0d expected 3", n_starts - s0); end
  endtask

  task automatic test_wrap();
    int s0;
    run = 1'b1;
    for (int g = 0; g < 80 && m_angle != 358; g++) begin
      angle_step = 3'(((358 - m_angle) > 7) ? 7 : (358 - m_angle));
      frame(4, 2);
    end
    checks++; if (vs_angle !== 9'd358) begin errors++; $display("FAIL wrap_pre: got %0d expected 358", vs_angle); end
    angle_step = 3'd3;
    frame(4, 2);
    checks++; if (vs_angle !== 9'd1) begin errors++; $display("FAIL wrap_angle: got %0d expected 1", vs_angle); end
    angle_step = 3'd0; s0 = n_starts;
    frame(4, 2);
    frame(4, 2);
    checks++; if (vs_angle !== 9'd1) begin errors++; $display("FAIL step0_angle: got %0d expected 1", vs_angle); end
    checks++; if (n_starts - s0 !== 2) begin errors++; $display("FAIL step0_starts: got %0d expected 2", n_starts - s0); end
  endtask

  task automatic test_overrun();
    int cap [6];
    int s0;
    angle_step = 3'd1; s0 = n_starts;
    frame(8, -1);
    frame(8, 5);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0b expected 1", overrun); end
    checks++; if (vs_angle !== 9'd2) begin errors++; $display("FAIL ovr_angle: got %0d expected 2", vs_angle); end
    checks++; if (n_starts - s0 !== 1) begin errors++; $display("FAIL ovr_starts: got %0d expected 1", n_starts - s0); end
    checks++; if (frame_cnt !== NW'(m_frames)) begin errors++; $display("FAIL ovr_frame_cnt: got %0d expected %0d", frame_cnt, m_frames); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (obs[k] !== CW'(m_front[k])) begin errors++; $display("FAIL ovr_front_hold[%0d]: got %0d expected %0d", k, obs[k], m_front[k]); end
    end
    cap = last_done;
    frame(8, 5);
    for (int k = 0; k < 6; k++) begin
      checks++; if (obs[k] !== CW'(cap[k])) begin errors++; $display("FAIL late_swap[%0d]: got %0d expected %0d", k, obs[k], cap[k]); end
    end
    checks++; if (vs_angle !== 9'd3) begin errors++; $display("FAIL late_angle: got %0d expected 3", vs_angle); end
    clr_overrun = 1'b1; vsync = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %0b expected 0", overrun); end
  endtask

  task automatic test_coincident();
    frame(8, -1);
    vsync = 1'b0; vs_done = 1'b1;
    tick();
    vs_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (obs[k] !== CW'(last_drv[k])) begin errors++; $display("FAIL coinc_front[%0d]: got %0d expected %0d", k, obs[k], last_drv[k]); end
    end
    checks++; if (vs_start !== 1'b1) begin errors++; $display("FAIL coinc_start: got %0b expected 1", vs_start); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coinc_overrun: got %0b expected 0", overrun); end
    checks++; if (vs_angle !== 9'd5) begin errors++; $display("FAIL coinc_angle: got %0d expected 5", vs_angle); end
    vsync = 1'b0; tick();
    vsync = 1'b1; vs_done = 1'b1; tick();
    vs_done = 1'b0; tick(); tick();
  endtask

  task automatic test_freeze();
    int cap [6];
    int s0, f0;
    cap = last_done; s0 = n_starts; f0 = m_frames; run = 1'b0;
    repeat (4) frame(6, -1);
    checks++; if (n_starts !== s0) begin errors++; $display("FAIL freeze_starts: got %0d expected %0d", n_starts, s0); end
    checks++; if (vs_angle !== 9'd5) begin errors++; $display("FAIL freeze_angle: got %0d expected 5", vs_angle); end
    checks++; if (frame_cnt !== NW'(f0 + 4)) begin errors++; $display("FAIL freeze_frame_cnt: got %0d expected %0d", frame_cnt, f0 + 4); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (obs[k] !== CW'(cap[k])) begin errors++; $display("FAIL freeze_front[%0d]: got %0d expected %0d", k, obs[k], cap[k]); end
    end
  endtask

  task automatic test_reset_busy();
    run = 1'b1; angle_step = 3'd2;
    frame(6, -1);
    resetn = 1'b0; tick(); tick();
    resetn = 1'b1; vsync = 1'b1; vs_done = 1'b1; tick();
    vs_done = 1'b0;
    checks++; if (vs_angle !== '0) begin errors++; $display("FAIL rst_busy_angle: got %0d expected 0", vs_angle); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL rst_busy_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (vs_start !== 1'b0) begin errors++; $display("FAIL rst_busy_start: got %0b expected 0", vs_start); end
    frame(6, -1);
    checks++; if (vs_angle !== 9'd2) begin errors++; $display("FAIL rst_busy_restart: got %0d expected 2", vs_angle); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (obs[k] !== '0) begin errors++; $display("FAIL stray_done_front[%0d]: got %0d expected 0", k, obs[k]); end
    end
    vsync = 1'b0; clr_overrun = 1'b1; tick();
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %0b expected 1", overrun); end
    vsync = 1'b0; tick();
    vsync = 1'b1; tick();
  endtask

  task automatic test_random();
    int len, done_at;
    resetn = 1'b0; tick(); tick();
    resetn = 1'b1; vsync = 1'b1; tick();
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(4, 24);
      done_at = $urandom_range(0, len + 8);
      run = ($urandom_range(0, 3) != 0);
      angle_step = 3'($urandom_range(0, 7));
      for (int i = 0; i < len; i++) begin
        vsync = (i < 2) ? 1'b0 : 1'b1;
        vs_done = (i == done_at);
        clr_overrun = ($urandom_range(0, 15) == 0);
        tick();
        checks++; if (vs_angle !== AW'(m_angle)) begin errors++; $display("FAIL rnd_angle f%0d c%0d: got %0d expected %0d", f, i, vs_angle, m_angle); end
        checks++; if (vs_start !== m_start) begin errors++; $display("FAIL rnd_start f%0d c%0d: got %0b expected %0b", f, i, vs_start, m_start); end
        checks++; if (frame_cnt !== NW'(m_frames)) begin errors++; $display("FAIL rnd_frame_cnt f%0d c%0d: got %0d expected %0d", f, i, frame_cnt, m_frames); end
        checks++; if (overrun !== m_ov) begin errors++; $display("FAIL rnd_overrun f%0d c%0d: got %0b expected %0b", f, i, overrun, m_ov); end
        for (int k = 0; k < 6; k++) begin
          checks++; if (obs[k] !== CW'(m_front[k])) begin errors++; $display("FAIL rnd_front[%0d] f%0d c%0d: got %0d expected %0d", k, f, i, obs[k], m_front[k]); end
        end
      end
    end
    vs_done = 1'b0; clr_overrun = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin drv[k] = '0; last_drv[k] = 0; last_done[k] = 0; end
    test_reset();
    test_basic();
    test_wrap();
    test_overrun();
    test_coincident();
    test_freeze();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
